dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the processor datapath (load/store port) and a host/debug loader port. It sits between `data_path`'s memory interface and the data memory, grants one access per cycle, and routes read data back to the owner of each read. It provides round-robin fairness plus a bounded host lock for burst program/data loading.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width.
- `MAX_LOCK`, default 8: maximum consecutive host grants under `host_lock` while the core is requesting.

Ports:
- `clk` in, 1 bit: single clock, rising edge.
- `reset` in, 1 bit: asynchronous, active-high.
- `core_req` in, 1 bit: core access request.
- `core_we` in, 1 bit: 1 = store, 0 = load.
- `core_addr` in, `ADDR_W` bits: core address.
- `core_wdata` in, `DATA_W` bits: core store data.
- `core_gnt` out, 1 bit: core access accepted this cycle.
- `core_rvalid` out, 1 bit: core load data valid.
- `core_rdata` out, `DATA_W` bits: core load data.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same roles as the core ports, for the host.
- `host_lock` in, 1 bit: host requests back-to-back grants.
- `mem_en` out, 1 bit: memory access strobe.
- `mem_we` out, 1 bit: memory write enable.
- `mem_addr` out, `ADDR_W` bits: memory address.
- `mem_wdata` out, `DATA_W` bits: memory write data.
- `mem_rdata` in, `DATA_W` bits: read data, valid exactly 1 cycle after a read strobe.

## Operation
- At most one grant per cycle. `mem_en = core_gnt | host_gnt`. `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted requester. When idle they are all 0.
- Priority register `prio` holds CORE or HOST; the requester named by `prio` wins a tie.
  - After every grant, `prio` flips to the other requester.
  - Exception: an active host lock keeps `prio` at HOST.
- A single requester is always granted immediately, whatever the state of `prio`.
- Host lock:
  - While `host_req & host_lock` and the last grant went to the host, the host keeps priority.
  - `lock_cnt` counts consecutive locked host grants that occur while `core_req` is high.
  - When `lock_cnt` reaches `MAX_LOCK`, the next contended cycle goes to the core and `lock_cnt` clears.
  - `lock_cnt` also clears on any core grant and whenever `host_lock` is low.
- Read return:
  - On a granted read, `rd_pending <= 1` and `rd_owner <=` the granted requester.
  - Next cycle, the owner's `rvalid = 1` and its `rdata = mem_rdata`.
  - A non-owner's `rdata` holds its last value.
- Writes produce no response. The grant cycle is the commit cycle.
- A requester must hold `req`, `we`, `addr` and `wdata` stable until `gnt`. The arbiter does not check this.

## Timing
- `gnt` is combinational from `req`, `prio`, `lock_cnt` and `host_lock` in the same cycle. There is no registered path from `req` to `gnt`.
- Read latency is 1 cycle from grant to `rvalid`. Back-to-back reads give one `rvalid` per cycle, owners interleaved.
- Reset values:
  - `prio` = CORE; `lock_cnt` = 0; `rd_pending` = 0.
  - `core_rvalid` = `host_rvalid` = 0.
  - `core_rdata` = `host_rdata` = 0.
  - All `mem_*` outputs = 0 (`gnt` outputs are 0 because `req` is masked while `reset` is high).
- Reset asserted with a read in flight: the pending `rvalid` is dropped and never issued.
- Simultaneous grant and return: a new read granted in the same cycle as a previous read's `rvalid` is legal. The owner register updates for the new read.
- Lock counting saturates at `MAX_LOCK` and never wraps. If `MAX_LOCK` = 0, the lock is disabled and the arbiter is plain round-robin.

## Structure
- Package `dmem_arb_pkg`:
  - `owner_t` enum `{OWNER_CORE, OWNER_HOST}`.
  - Default `MAX_LOCK` constant.
  - Lock counter width as `$clog2(MAX_LOCK+1)`.
- Sub-module `rr_pick2`:
  - Combinational two-way pick from `req[1:0]`, `prio` and `force_core`.
  - Outputs a one-hot `gnt[1:0]`.
- Owner, pending, counter and priority registers live in `dmem_arbiter`.

## Test plan
- Reset, then core read only: `core_req`=1, `core_addr`=0x10, `mem_rdata`=0xDEADBEEF → `core_gnt`=1 in cycle 0; `core_rvalid`=1 with `core_rdata`=0xDEADBEEF in cycle 1; `host_rvalid` stays 0.
- Both request continuously, no lock → grants alternate core, host, core, host starting with core; 4 reads return 4 `rvalid` pulses to the matching owners.
- `host_lock`=1 with both requesting, `MAX_LOCK`=8 → 8 consecutive host grants, then 1 core grant, then the host resumes; `lock_cnt` observed 0→8→0.
- Host write to 0x20 with 0x12345678, then core read of 0x20 → `mem_we`=1 on the host grant; the core read is granted the next cycle and returns 0x12345678.
- Read granted, `reset` pulsed in the following cycle before the clock edge → no `rvalid`; all outputs equal reset values; `prio`=CORE after release.
- Core store alone → `core_gnt`=1, `mem_we`=1, `mem_wdata`=`core_wdata`, and no `rvalid` on either port.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Who owns an access: the processor load/store port or the host loader.
  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } owner_t;

  // Default bound on consecutive locked host grants while the core waits.
  localparam int MAX_LOCK_DEFAULT = 8;

  // Counter width able to hold 0..max_lock; never narrower than one bit so
  // the lock-disabled build (max_lock = 0) still has a legal register.
  function automatic int lock_cnt_w(input int max_lock);
    if (max_lock < 1) return 1;
    return $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way pick: bit 0 = core, bit 1 = host, one-hot grant.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     prio,
  input  logic       force_core,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie force_core, then prio, decides.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (force_core || (prio == OWNER_CORE)) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core and the host loader.
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until gnt; the cycle in which req & gnt are both high is the commit cycle
// (writes land, reads launch), and read data comes back exactly one cycle
// later as rvalid/rdata on the port that issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LCW     = lock_cnt_w(MAX_LOCK);
  localparam bit LOCK_EN = (MAX_LOCK > 0);

  owner_t           r_prio;
  owner_t           w_prio_next;
  logic [LCW-1:0]   r_lock_cnt;
  logic [LCW-1:0]   w_lock_cnt_next;
  logic             r_rd_pending;
  owner_t           r_rd_owner;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_force_core;
  logic       w_rd_launch;
  logic       w_core_ret;
  logic       w_host_ret;

  // Requests are masked during reset so no grant can escape.
  assign w_req        = {host_req, core_req} & {2{~reset}};
  assign w_force_core = LOCK_EN && (r_lock_cnt == LCW'(MAX_LOCK));

  rr_pick2 u_pick (
    .req        (w_req),
    .prio       (r_prio),
    .force_core (w_force_core),
    .gnt        (w_gnt)
  );

  assign core_gnt    = w_gnt[0];
  assign host_gnt    = w_gnt[1];
  assign mem_en      = |w_gnt;
  assign w_rd_launch = mem_en & ~mem_we;

  // Route the granted requester onto the memory bus; all zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt[0]) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_gnt[1]) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Priority state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= OWNER_CORE;
    end else begin
      r_prio <= w_prio_next;
    end
  end

  // Priority flips after each grant, except a locked host grant keeps it.
  always_comb begin
    w_prio_next = r_prio;
    if (w_gnt[0]) begin
      w_prio_next = OWNER_HOST;
    end else if (w_gnt[1]) begin
      w_prio_next = (LOCK_EN && host_lock) ? OWNER_HOST : OWNER_CORE;
    end
  end

  // Count locked host grants taken while the core was kept waiting.
  always_comb begin
    w_lock_cnt_next = r_lock_cnt;
    if (!LOCK_EN || !host_lock || w_gnt[0]) begin
      w_lock_cnt_next = '0;
    end else if (w_gnt[1] && w_req[0] && (r_lock_cnt != LCW'(MAX_LOCK))) begin
      w_lock_cnt_next = r_lock_cnt + LCW'(1);
    end
  end

  // Lock counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_cnt <= '0;
    end else begin
      r_lock_cnt <= w_lock_cnt_next;
    end
  end

  // Remember whether a read is in flight and which port it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= OWNER_CORE;
    end else begin
      r_rd_pending <= w_rd_launch;
      if (w_rd_launch) begin
        r_rd_owner <= w_gnt[1] ? OWNER_HOST : OWNER_CORE;
      end
    end
  end

  assign w_core_ret = r_rd_pending & (r_rd_owner == OWNER_CORE);
  assign w_host_ret = r_rd_pending & (r_rd_owner == OWNER_HOST);

  // Hold each port's last returned word so a non-owner's rdata stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_core_ret) r_core_rdata <= mem_rdata;
      if (w_host_ret) r_host_rdata <= mem_rdata;
    end
  end

  assign core_rvalid = w_core_ret;
  assign host_rvalid = w_host_ret;
  assign core_rdata  = w_core_ret ? mem_rdata : r_core_rdata;
  assign host_rdata  = w_host_ret ? mem_rdata : r_host_rdata;

endmodule
